// File: rtl/msx_slot_mapper.sv
// msx_slot_mapper: MSX primary/secondary slot decode plus FC-FF memory mapper.
// Define SLOT_MAPPER_READBACK_EN to make the mapper ports readable.
module msx_slot_mapper #(
    parameter logic [3:0] EXPANDED    = 4'b1000,
    parameter int         MAPPER_SLOT = 3,
    parameter int         MAPPER_SUB  = 0,
    parameter int         SEG_BITS    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          addr,
    input  logic [7:0]           d_i,
    input  logic                 mreq_n,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 m1_n,
    input  logic                 rfrsh_n,
    input  logic [7:0]           prim_slot_i,
    output logic [7:0]           d_o,
    output logic                 d_oe,
    output logic [3:0]           sltsl_n,
    output logic [15:0]          subsl_n,
    output logic [SEG_BITS+13:0] ram_a,
    output logic                 ram_cs,
    output logic                 ram_we
);
    localparam int MAP_IDX = MAPPER_SLOT * 4 + (EXPANDED[MAPPER_SLOT] ? MAPPER_SUB : 0);

    logic [7:0]          ssr_q [4];
    logic [7:0]          ssr_d [4];
    logic [SEG_BITS-1:0] seg_q [4];
    logic [SEG_BITS-1:0] seg_d [4];
    logic                wr_seen_q, wr_seen_d;
    logic [1:0]          page, ps, pri3, sub;
    logic                mem_acc, io_acc, conflict, ffff_acc, io_hit, sel, wr_ev, rd_ffff, rd_io;

    assign page     = addr[15:14];
    assign ps       = prim_slot_i[{page, 1'b0} +: 2];
    assign pri3     = prim_slot_i[7:6];
    assign mem_acc  = ~mreq_n & rfrsh_n;
    assign io_acc   = ~iorq_n & m1_n;
    assign conflict = ~mreq_n & ~iorq_n;
    assign ffff_acc = mem_acc & (addr == 16'hFFFF) & EXPANDED[pri3];
    assign io_hit   = io_acc & (addr[7:2] == 6'h3F);
    assign sel      = mem_acc & ~ffff_acc;
    assign sub      = EXPANDED[ps] ? ssr_q[ps][{page, 1'b0} +: 2] : 2'd0;

    always_comb begin
        sltsl_n = '1;
        subsl_n = '1;
        if (sel) begin
            sltsl_n[ps]       = 1'b0;
            subsl_n[{ps, sub}] = 1'b0;
        end
    end

    assign ram_cs  = ~subsl_n[MAP_IDX];
    assign ram_a   = {seg_q[page], addr[13:0]};
    assign ram_we  = ram_cs & ~wr_n;
    assign rd_ffff = ffff_acc & ~rd_n & ~conflict & reset_n;
`ifdef SLOT_MAPPER_READBACK_EN
    assign rd_io   = io_hit & ~rd_n & ~conflict & reset_n;
`else
    assign rd_io   = 1'b0;
`endif
    assign d_oe = rd_ffff | rd_io;
    assign d_o  = rd_ffff ? ~ssr_q[pri3]
                : rd_io   ? ((8'hFF << SEG_BITS) | 8'(seg_q[addr[1:0]]))
                :           8'hFF;

    // wr_seen turns a multi-cycle CPU write strobe into a single commit
    assign wr_ev = ~wr_n & ~conflict & ~wr_seen_q & (ffff_acc | io_hit);

    always_comb begin
        ssr_d = ssr_q;
        seg_d = seg_q;
        if (wr_ev & ffff_acc) ssr_d[pri3] = d_i;
        if (wr_ev & io_hit) seg_d[addr[1:0]] = d_i[SEG_BITS-1:0];
        wr_seen_d = wr_n ? 1'b0 : (wr_seen_q | wr_ev);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                ssr_q[i] <= '0;
                seg_q[i] <= SEG_BITS'(3 - i);
            end
            wr_seen_q <= 1'b1;
        end else begin
            ssr_q     <= ssr_d;
            seg_q     <= seg_d;
            wr_seen_q <= wr_seen_d;
        end
    end
endmodule

// File: tb/tb_msx_slot_mapper.sv
// tb_msx_slot_mapper: directed plus random bus cycles checked against an arithmetic slot/mapper model.
module tb_msx_slot_mapper;
    logic        clk = 0, reset_n = 0;
    logic [15:0] addr = 0;
    logic [7:0]  d_i = 0, prim_slot_i = 8'hFF;
    logic        mreq_n = 1, iorq_n = 1, rd_n = 1, wr_n = 1, m1_n = 1, rfrsh_n = 1;
    logic [7:0]  d_o;
    logic        d_oe, ram_cs, ram_we;
    logic [3:0]  sltsl_n;
    logic [15:0] subsl_n;
    logic [16:0] ram_a;

    int total = 0, passed = 0;
    logic [7:0] m_ssr [4];
    int         m_seg [4];

    msx_slot_mapper dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .d_i(d_i),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfrsh_n(rfrsh_n),
        .prim_slot_i(prim_slot_i), .d_o(d_o), .d_oe(d_oe), .sltsl_n(sltsl_n), .subsl_n(subsl_n),
        .ram_a(ram_a), .ram_cs(ram_cs), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfrsh_n = 1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_ssr[i] = 8'h00;
            m_seg[i] = 3 - i;
        end
    endtask

    task automatic access(input bit io, input bit wr, input logic [15:0] a,
                          input logic [7:0] ps, input logic [7:0] d, input int hold);
        int pg, s, sb, port;
        bit ffff, iohit, sel, e_cs, e_oe;
        logic [7:0] e_do;
        @(negedge clk);
        addr = a; prim_slot_i = ps; d_i = d;
        mreq_n = io; iorq_n = !io; rd_n = wr; wr_n = !wr;
        #1;
        pg    = a / 16384;
        s     = (ps >> (2 * pg)) % 4;
        sb    = (s == 3) ? (m_ssr[s] >> (2 * pg)) % 4 : 0;
        ffff  = !io && a == 16'hFFFF && (ps >> 6) == 3;
        port  = a % 256;
        iohit = io && port >= 252;
        sel   = !io && !ffff;
        e_cs  = sel && s == 3 && sb == 0;
        e_oe  = 0;
        e_do  = 8'hFF;
        if (ffff && !wr) begin
            e_oe = 1;
            e_do = 8'(255 - m_ssr[ps >> 6]);
        end
`ifdef SLOT_MAPPER_READBACK_EN
        if (iohit && !wr) begin
            e_oe = 1;
            e_do = 8'(248 + m_seg[port - 252]);
        end
`endif
        chk("sltsl_n", sltsl_n, sel ? 4'(15 - (1 << s)) : 4'hF);
        chk("subsl_n", subsl_n, sel ? 16'(65535 - (1 << (s * 4 + sb))) : 16'hFFFF);
        chk("ram_cs", ram_cs, e_cs);
        chk("ram_we", ram_we, e_cs && wr);
        chk("ram_a", ram_a, 17'(m_seg[pg] * 16384 + a % 16384));
        chk("d_oe", d_oe, e_oe);
        chk("d_o", d_o, e_do);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        idle();
        if (wr && ffff) m_ssr[ps >> 6] = d;
        if (wr && iohit) m_seg[port - 252] = d % 8;
    endtask

    initial begin
        idle();
        m_reset();
        // FFFF read held during reset must not drive the bus
        addr = 16'hFFFF; mreq_n = 0; rd_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_d_oe", d_oe, 0);
        chk("rst_d_o", d_o, 8'hFF);
        chk("rst_sltsl", sltsl_n, 4'hF);
        chk("rst_ram_a", ram_a, 17'h03FFF);
        idle();
        @(negedge clk);
        reset_n = 1;

        access(0, 0, 16'h4000, 8'hFF, 8'h00, 2);
        access(0, 1, 16'hFFFF, 8'hFF, 8'h6C, 3);
        access(0, 0, 16'hFFFF, 8'hFF, 8'h00, 2);
        access(1, 1, 16'h00FE, 8'hFF, 8'hFF, 3);
        access(0, 0, 16'h8123, 8'hFF, 8'h00, 2);
        access(1, 0, 16'h00FE, 8'hFF, 8'h00, 2);

        // long write strobe with data changing mid-strobe: only the first value lands
        @(negedge clk);
        addr = 16'h00FC; d_i = 8'd5; iorq_n = 0; wr_n = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        d_i = 8'd6;
        repeat (6) @(posedge clk);
        @(negedge clk);
        idle();
        m_seg[0] = 5;
        access(0, 0, 16'h0123, 8'hFF, 8'h00, 2);
        access(1, 0, 16'h00FC, 8'hFF, 8'h00, 2);

        // reset asserted during a mapper write, released with wr_n still low
        @(negedge clk);
        addr = 16'h00FD; d_i = 8'd7; iorq_n = 0; wr_n = 0; reset_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle();
        access(0, 0, 16'h4000, 8'hFF, 8'h00, 2);
        access(1, 0, 16'h00FD, 8'hFF, 8'h00, 2);

        // simultaneous mreq_n/iorq_n: no commit, no drive
        @(negedge clk);
        addr = 16'hFFFF; prim_slot_i = 8'hFF; d_i = 8'hA5; mreq_n = 0; iorq_n = 0; wr_n = 0;
        #1;
        chk("both_wr_d_oe", d_oe, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        wr_n = 1; rd_n = 0;
        #1;
        chk("both_rd_d_oe", d_oe, 0);
        @(negedge clk);
        addr = 16'h00FC; d_i = 8'h01; rd_n = 1; wr_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle();
        access(0, 0, 16'hFFFF, 8'hFF, 8'h00, 2);
        access(0, 0, 16'h0000, 8'hFF, 8'h00, 2);
        access(0, 0, 16'hC000, 8'hFF, 8'h00, 2);

        for (int n = 0; n < 300; n++) begin
            bit io, wr;
            logic [15:0] a;
            logic [7:0] ps;
            io = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ps = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            if (io) a = {8'($urandom), 8'($urandom_range(248, 255))};
            else a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            access(io, wr, a, ps, 8'($urandom), $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
